// File: rtl/vm_session_timer_pkg.sv
// Shared definitions for the vending machine session timer.
// Machine-wide sizes, default timings and timer state encoding.
package vm_session_timer_pkg;

    localparam int kNumCoins = 4;
    localparam int kNumItems = 8;
    localparam int kWaitTime = 10;
    localparam int kWarnTime = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WARN   = 2'd2
    } state_t;

endpackage

// File: rtl/vm_session_timer_tick.sv
// Prescaler for the session timer: one tick every PRESCALE enabled cycles.
// Clear has priority over enable; disabled cycles freeze the count.
module vm_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/vm_session_timer.sv
// Session timer beside the vending machine FSM.
// Reloads on coin/valid selection, warns near expiry, pulses on timeout.
import vm_session_timer_pkg::*;

module vm_session_timer #(
    parameter int NUM_COINS = kNumCoins,
    parameter int NUM_ITEMS = kNumItems,
    parameter int CNT_W     = 8,
    parameter int WAIT_TIME = kWaitTime,
    parameter int WARN_TIME = kWarnTime,
    parameter int PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_COINS-1:0] i_input_coin,
    input  logic [NUM_ITEMS-1:0] i_select_item,
    input  logic [NUM_ITEMS-1:0] i_available_item,
    input  logic                 i_hold,
    input  logic                 i_cancel,
    input  logic [CNT_W-1:0]     i_cfg_wait,
    output logic [CNT_W-1:0]     wait_time,
    output logic                 o_active,
    output logic                 o_warning,
    output logic                 o_timeout
);

    localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_TIME);

    state_t           state;
    logic             restart;
    logic             run;
    logic             tick;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] dec_val;

    assign restart  = (|i_input_coin) |
                      (|(i_select_item & i_available_item));
    assign load_val = (i_cfg_wait != '0) ? i_cfg_wait
                                         : CNT_W'(WAIT_TIME);
    assign run      = (state != ST_IDLE) && !i_hold;
    assign dec_val  = wait_time - CNT_W'(1);

    vm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (i_cancel | restart),
        .enable  (run),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wait_time <= '0;
            o_active  <= 1'b0;
            o_warning <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (i_cancel) begin
                state     <= ST_IDLE;
                wait_time <= '0;
                o_active  <= 1'b0;
                o_warning <= 1'b0;
            end else if (restart) begin
                wait_time <= load_val;
                o_active  <= 1'b1;
                if (load_val <= WARN_V) begin
                    state     <= ST_WARN;
                    o_warning <= 1'b1;
                end else begin
                    state     <= ST_ACTIVE;
                    o_warning <= 1'b0;
                end
            end else if (tick) begin
                // tick only fires in ACTIVE/WARN, where wait_time != 0
                if (wait_time > CNT_W'(1)) begin
                    wait_time <= dec_val;
                    if (dec_val <= WARN_V) begin
                        state     <= ST_WARN;
                        o_warning <= 1'b1;
                    end
                end else begin
                    state     <= ST_IDLE;
                    wait_time <= '0;
                    o_active  <= 1'b0;
                    o_warning <= 1'b0;
                    o_timeout <= 1'b1;
                end
            end
        end
    end

endmodule
